// File: rtl/cpu_pkg.sv
// Shared core package: default word width and the index-width helper.
// Used by stream_mux and stream_arb.
package cpu_pkg;

  localparam int WORD_W = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_arb.sv
// Channel arbiter for stream_mux: one-hot grant plus binary index.
// STREAM_MUX_RR_EN selects round-robin; otherwise lowest index wins.
module stream_arb
  import cpu_pkg::*;
#(
  parameter int N = 2,
  localparam int SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  logic found;

`ifdef STREAM_MUX_RR_EN
  int j;

  // Scan from ptr upward, wrapping; N need not be a power of two.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = SELW'(j);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = SELW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream mux with registered output stage.
// Arbitration: round-robin when STREAM_MUX_RR_EN is defined, else fixed.
module stream_mux
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int N = 2,
  localparam int SELW = clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  ptr;
  logic [WIDTH-1:0] sel_data;
  logic             can_load;
  logic             load;

  assign can_load = !out_valid || out_ready;
  assign load     = can_load && |in_valid;
  assign in_ready = grant & {N{can_load}};

  stream_arb #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

`ifdef STREAM_MUX_RR_EN
  logic [SELW-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (load) begin
      rr_ptr <= (grant_idx == SELW'(N - 1)) ?
                '0 : grant_idx + SELW'(1);
    end
  end

  assign ptr = rr_ptr;
`else
  assign ptr = '0;
`endif

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // A load replaces a beat leaving in the same cycle: no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux (N=3): directed cases plus
// randomized traffic against a transaction-level reference model.
module tb_stream_mux;

  localparam int W = 32;
  localparam int N = 3;
  localparam int SW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  int errors = 0;
  int checks = 0;

  // Reference model state: the beat the output should hold.
  bit         m_valid;
  bit [W-1:0] m_data;
  int         m_sel;
  int         m_ptr;

  stream_mux #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    int j;
`ifdef STREAM_MUX_RR_EN
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (v[j]) return j;
    end
`else
    for (j = 0; j < N; j++) begin
      if (v[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  task automatic set_d(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  // Called at negedge with inputs driven; ends at the next negedge.
  task automatic step();
    int g;
    bit can;
    logic [N-1:0] er;
    #1;
    g   = model_grant(in_valid);
    can = !m_valid || out_ready;
    er  = '0;
    if (g >= 0 && can) er[g] = 1'b1;
    check("in_ready", 64'(in_ready), 64'(er));
    if (g >= 0 && can) begin
      m_valid = 1;
      m_data  = in_data[g*W +: W];
      m_sel   = g;
      m_ptr   = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check("out_data", 64'(out_data), 64'(m_data));
      check("out_sel", 64'(out_sel), 64'(m_sel));
    end
    @(negedge clk);
  endtask

  int exp_rr[6];
  int exp_sk[4];

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_sel", 64'(out_sel), 64'd0);
    rst_n = 1'b1;

    // Stall hold: ch0 loads, then held for 3 cycles.
    in_valid = 3'b011;
    set_d(0, 32'h1111_1111);
    set_d(1, 32'h2222_2222);
    step();
    check("stall_load_data", 64'(out_data), 64'h1111_1111);
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_ready", 64'(in_ready), 64'd0);
      check("stall_data", 64'(out_data), 64'h1111_1111);
      check("stall_sel", 64'(out_sel), 64'd0);
    end

    // Withdrawal: ch1 alone for one stalled cycle, then gone.
    in_valid = 3'b010;
    step();
    in_valid  = 3'b100;
    set_d(2, 32'h3333_3333);
    out_ready = 1'b1;
    step();
    check("wd_sel", 64'(out_sel), 64'd2);
    check("wd_data", 64'(out_data), 64'h3333_3333);

    // Full throughput on ch0.
    in_valid = 3'b001;
    for (int i = 0; i < 4; i++) begin
      set_d(0, 32'(i));
      step();
      check("tp_valid", 64'(out_valid), 64'd1);
      check("tp_data", 64'(out_data), 64'(i));
    end

    // Reset mid-stall, between clock edges.
    in_valid  = 3'b010;
    set_d(1, 32'hdead_beef);
    out_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    check("arst_sel", 64'(out_sel), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // All channels valid: round-robin rotates, fixed sticks to 0.
    out_ready = 1'b1;
    in_valid  = 3'b111;
`ifdef STREAM_MUX_RR_EN
    exp_rr = '{0, 1, 2, 0, 1, 2};
    exp_sk = '{0, 2, 0, 2};
`else
    exp_rr = '{0, 0, 0, 0, 0, 0};
    exp_sk = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_sel", 64'(out_sel), 64'(exp_rr[i]));
    end
    in_valid = 3'b101;
    for (int i = 0; i < 4; i++) begin
      step();
      check("skip_sel", 64'(out_sel), 64'(exp_sk[i]));
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) set_d(i, $urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
